// File: rtl/sram_bus_arbiter_pkg.sv
// Shared constants and types for the SRAM bus arbiter: owner codes, SRAM size codes and the
// owner-FIFO entry layout.
package sram_bus_arbiter_pkg;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef struct packed {
    logic owner;
    logic cancelled;
  } arb_entry_t;

  localparam int unsigned ENTRY_W = $bits(arb_entry_t);

endpackage

// File: rtl/arb_owner_fifo.sv
// In-order owner tracking FIFO: one entry per accepted memory transaction, with a broadcast
// cancel that marks every instruction entry (including one being pushed) as dropped.
module arb_owner_fifo
  import sram_bus_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             push_owner,
  input  logic             pop,
  input  logic             cancel,
  output logic             head_owner,
  output logic             head_cancelled,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  arb_entry_t            entries_q [DEPTH];
  logic       [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic       [CNT_W-1:0] count_q;
  arb_entry_t            push_entry;

  always_comb begin
    push_entry.owner     = push_owner;
    push_entry.cancelled = cancel && (push_owner == OWNER_INST);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (cancel && (entries_q[i].owner == OWNER_INST)) begin
          entries_q[i].cancelled <= 1'b1;
        end
      end
      // Later assignment wins for the slot being written this cycle.
      if (push) begin
        entries_q[wr_ptr_q] <= push_entry;
        wr_ptr_q <= (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_owner     = entries_q[rd_ptr_q].owner;
  assign head_cancelled = entries_q[rd_ptr_q].cancelled;
  assign count          = count_q;
  assign full           = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like port between fetch and memory stages; tracks in-order outstanding
// transactions, routes responses to their owner and drops responses of cancelled fetches.
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int unsigned OUTSTANDING = 2,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [ADDR_W-1:0] inst_rdata,
  input  logic              inst_cancel,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [ADDR_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [ADDR_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [ADDR_W-1:0] mem_rdata,
  output logic              busy,
  output logic              proto_err
);

  localparam int unsigned CntW = $clog2(OUTSTANDING + 1);

  logic            lock_q, lock_owner_q, proto_err_q;
  logic            grant_valid, grant_owner, issue, accept, pop;
  logic            head_owner, head_cancelled, full;
  logic [CntW-1:0] count;

  // A locked owner keeps the grant; if it drops its request nobody is granted this cycle.
  always_comb begin
    grant_valid = 1'b0;
    grant_owner = OWNER_INST;
    if (lock_q) begin
      grant_owner = lock_owner_q;
      grant_valid = (lock_owner_q == OWNER_DATA) ? data_req : inst_req;
    end else if (data_req) begin
      grant_valid = 1'b1;
      grant_owner = OWNER_DATA;
    end else if (inst_req) begin
      grant_valid = 1'b1;
    end
  end

  assign issue  = grant_valid && !full;
  assign accept = issue && mem_addr_ok;
  assign pop    = mem_data_ok && (count != '0);

  always_comb begin
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_size  = SIZE_B;
    mem_wstrb = 4'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (issue) begin
      mem_req = 1'b1;
      if (grant_owner == OWNER_DATA) begin
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_wstrb = data_wstrb;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end else begin
        mem_size = SIZE_W;
        mem_addr = inst_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      lock_q       <= 1'b0;
      lock_owner_q <= OWNER_INST;
      proto_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        lock_q <= 1'b0;
      end else if (lock_q) begin
        if (!grant_valid || (inst_cancel && (lock_owner_q == OWNER_INST))) begin
          lock_q <= 1'b0;
        end
      end else if (issue && !(inst_cancel && (grant_owner == OWNER_INST))) begin
        lock_q       <= 1'b1;
        lock_owner_q <= grant_owner;
      end
      if (mem_data_ok && (count == '0)) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  arb_owner_fifo #(
    .DEPTH (OUTSTANDING),
    .CNT_W (CntW)
  ) u_owner_fifo (
    .clk            (clk),
    .rstn           (rstn),
    .push           (accept),
    .push_owner     (grant_owner),
    .pop            (pop),
    .cancel         (inst_cancel),
    .head_owner     (head_owner),
    .head_cancelled (head_cancelled),
    .count          (count),
    .full           (full)
  );

  assign inst_addr_ok = accept && (grant_owner == OWNER_INST);
  assign data_addr_ok = accept && (grant_owner == OWNER_DATA);
  assign inst_data_ok = pop && (head_owner == OWNER_INST) && !head_cancelled;
  assign data_data_ok = pop && (head_owner == OWNER_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign busy         = (count != '0);
  assign proto_err    = proto_err_q;

endmodule
